sevseg_count_mux: RTL

- Consumes single-cycle debounced button pulses and keeps a 4-digit BCD count, 0000–9999.
- Drives a time-multiplexed, common-anode 4-digit seven-segment display from that count.
- Sits directly downstream of the debouncer instances: their `trans_dn`/`trans_up` outputs connect straight to the pulse inputs.
- Scan blanking between digits suppresses ghosting.

---
 rtl/sevseg_count_mux.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sevseg_count_mux.sv
// 4-digit BCD up/down counter driving a multiplexed common-anode seven-segment display.
// Optional leading-zero blanking: define SEVSEG_LEADING_ZERO_BLANK_EN.
module sevseg_count_mux #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        inc_pulse,
  input  logic        dec_pulse,
  input  logic        clr_pulse,
  output logic [15:0] count_bcd,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int unsigned P_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [P_W-1:0] P_LAST = P_W'(SCAN_DIV - 1);

  logic [15:0]    r_count;
  logic [P_W-1:0] r_p;
  logic [1:0]     r_idx;
  logic [6:0]     r_seg;
  logic [3:0]     r_an;

  logic [15:0]    w_count_nxt;
  logic [P_W-1:0] w_p_nxt;
  logic [1:0]     w_idx_nxt;
  logic [3:0]     w_nibble;
  logic [6:0]     w_seg_nxt;
  logic [3:0]     w_an_nxt;
  logic           w_in_blank;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] res;
    logic        borrow;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes go dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Counter next value: clear wins, opposing inc/dec cancel.
  always_comb begin
    w_count_nxt = r_count;
    if (clr_pulse) begin
      w_count_nxt = 16'h0000;
    end else if (inc_pulse && !dec_pulse) begin
      w_count_nxt = bcd_inc(r_count);
    end else if (dec_pulse && !inc_pulse) begin
      w_count_nxt = bcd_dec(r_count);
    end
  end

  // Prescaler and digit index.
  always_comb begin
    w_p_nxt   = r_p + P_W'(1);
    w_idx_nxt = r_idx;
    if (r_p == P_LAST) begin
      w_p_nxt   = '0;
      w_idx_nxt = r_idx + 2'd1;
    end
  end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  logic [3:0] w_lead_zero;
  always_comb begin
    w_lead_zero    = 4'b0000;
    w_lead_zero[3] = (r_count[15:12] == 4'd0);
    w_lead_zero[2] = w_lead_zero[3] && (r_count[11:8] == 4'd0);
    w_lead_zero[1] = w_lead_zero[2] && (r_count[7:4] == 4'd0);
  end
`endif

  // Display output next values from the current scan position and count.
  always_comb begin
    w_in_blank = (32'(r_p) < BLANK_CYCLES);
    w_nibble   = r_count[{r_idx, 2'b00} +: 4];
    w_seg_nxt  = seg_decode(w_nibble);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    if (w_lead_zero[r_idx]) begin
      w_seg_nxt = 7'b1111111;
    end
`endif
    w_an_nxt = w_in_blank ? 4'b1111 : ~(4'b0001 << r_idx);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= 16'h0000;
      r_p     <= '0;
      r_idx   <= 2'd0;
      r_seg   <= 7'b1111111;
      r_an    <= 4'b1111;
    end else begin
      r_count <= w_count_nxt;
      r_p     <= w_p_nxt;
      r_idx   <= w_idx_nxt;
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
    end
  end

  assign count_bcd = r_count;
  assign seg       = r_seg;
  assign an        = r_an;
  assign dp        = 1'b1;

endmodule
